serial_tmr_subtractor: RTL and testbench

SERIAL_TMR_SUBTRACTOR -- requirements
Module: serial_tmr_subtractor

---
 rtl/serial_tmr_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_tmr_subtractor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tmr_subtractor.sv
// Bit-serial subtractor (x - y mod 2^W) with a triple-redundant borrow chain.
// One bit is processed per clock, LSB first. The borrow is held in three
// replicas. Each replica computes its own borrow-out from its own stored
// value. The borrow-in used for the difference bit is the 2-of-3 majority.
// Any cycle in which the replicas disagree sets a sticky fault flag and
// bumps a saturating 4-bit counter.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - begin a subtraction (sampled only in IDLE)
//   x, y      - minuend / subtrahend, captured when start is accepted
//   inj       - per-replica inversion of the written borrow (RUN only)
//   busy      - high while in RUN
//   done      - one-cycle pulse when the result is valid
//   d         - difference
//   b         - voted borrow-out (x < y unsigned)
//   fault     - sticky replica disagreement flag
//   fault_cnt - disagreement cycle count, saturating at 15
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | processing bit idx, one per cycle
// DONE  | result valid, done pulses for this one cycle
module serial_tmr_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   inj,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         b,
  output logic         fault,
  output logic [3:0]   fault_cnt
);

  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  x_q, y_q;
  logic [IW-1:0] idx;
  logic [2:0]    rep;

  logic          xi, yi, bin, di, last;
  logic [2:0]    bout, rep_nx;
  logic          dis_old, dis_new;
  logic [1:0]    inc;
  logic [4:0]    cnt_sum;
  logic [3:0]    cnt_sat;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_comb begin
    xi   = x_q[idx];
    yi   = y_q[idx];
    bin  = maj3(rep);
    di   = xi ^ yi ^ bin;
    last = (idx == IW'(W - 1));
    for (int r = 0; r < 3; r++) begin
      bout[r] = (~xi & yi) | (~(xi ^ yi) & rep[r]);
    end
    rep_nx  = bout ^ inj;
    dis_old = (rep != 3'b000) && (rep != 3'b111);
    dis_new = (rep_nx != 3'b000) && (rep_nx != 3'b111);
    // On the final edge the freshly written replicas are checked too, so
    // that edge can contribute up to two disagreement events.
    inc     = {1'b0, dis_old} + {1'b0, last & dis_new};
    cnt_sum = {1'b0, fault_cnt} + {3'b000, inc};
    cnt_sat = (cnt_sum > 5'd15) ? 4'd15 : cnt_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      idx       <= '0;
      rep       <= '0;
      d         <= '0;
      b         <= 1'b0;
      fault     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q       <= x;
            y_q       <= y;
            idx       <= '0;
            rep       <= '0;
            d         <= '0;
            b         <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
          end
        end
        RUN: begin
          d[idx]    <= di;
          rep       <= rep_nx;
          idx       <= idx + 1'b1;
          fault_cnt <= cnt_sat;
          if (inc != 2'd0) fault <= 1'b1;
          if (last) b <= maj3(rep_nx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tmr_subtractor.sv
// Self-checking bench for serial_tmr_subtractor: a W=8 instance driven by a
// vector table, random operands/injections and hand-written corner
// sequences, plus a W=32 instance used for counter saturation.
module tb_serial_tmr_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x, y;
  logic [2:0]  inj;
  logic        busy, done, b, fault;
  logic [7:0]  d;
  logic [3:0]  fault_cnt;

  logic        start32;
  logic [31:0] x32, y32;
  logic [2:0]  inj32;
  logic        busy32, done32, b32, fault32;
  logic [31:0] d32;
  logic [3:0]  cnt32;

  int n_cmp = 0;
  int n_bad = 0;

  serial_tmr_subtractor #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .inj(inj),
    .busy(busy), .done(done), .d(d), .b(b), .fault(fault), .fault_cnt(fault_cnt)
  );

  serial_tmr_subtractor #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .x(x32), .y(y32), .inj(inj32),
    .busy(busy32), .done(done32), .d(d32), .b(b32), .fault(fault32), .fault_cnt(cnt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each replica's borrow is the sign of (xi - yi - replica);
  // the difference bit is the low bit of (xi - yi - majority).
  // ic = -1: no injection, ic = -2: inject every cycle, else at bit ic.
  function automatic void model(input int n, input logic [31:0] xv, input logic [31:0] yv,
                                input logic [2:0] iv, input int ic,
                                output logic [31:0] dv, output logic bv, output int cnt);
    int rep[3];
    int nr[3];
    int bin, diff, xi, yi;
    rep = '{0, 0, 0};
    dv  = '0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      xi = int'(xv[i]);
      yi = int'(yv[i]);
      if (!(rep[0] == rep[1] && rep[1] == rep[2])) cnt++;
      bin   = (rep[0] + rep[1] + rep[2] >= 2) ? 1 : 0;
      diff  = xi - yi - bin;
      dv[i] = diff[0];
      for (int r = 0; r < 3; r++) begin
        nr[r] = ((xi - yi - rep[r]) < 0) ? 1 : 0;
        if (ic == -2 || ic == i) nr[r] = nr[r] ^ int'(iv[r]);
      end
      rep = nr;
    end
    if (!(rep[0] == rep[1] && rep[1] == rep[2])) cnt++;
    bv = (rep[0] + rep[1] + rep[2] >= 2);
    if (cnt > 15) cnt = 15;
  endfunction

  task automatic run_op(input string nm, input logic [7:0] xv, input logic [7:0] yv,
                        input logic [2:0] iv, input int ic,
                        input logic [7:0] ed, input logic eb, input logic ef,
                        input logic [3:0] ec);
    @(posedge clk); #1;
    x = xv; y = yv; start = 1'b1; inj = 3'b111;
    @(posedge clk); #1;
    start = 1'b0; x = ~xv; y = ~yv;
    for (int c = 0; c < 8; c++) begin
      inj = (c == ic) ? iv : 3'b000;
      @(negedge clk);
      if (c > 0) check({nm, " busy"}, 32'(busy), 1);
      check({nm, " early done"}, 32'(done), 0);
      @(posedge clk); #1;
    end
    inj = 3'b111;
    @(negedge clk);
    check({nm, " done"}, 32'(done), 1);
    check({nm, " busy at done"}, 32'(busy), 0);
    check({nm, " d"}, 32'(d), 32'(ed));
    check({nm, " b"}, 32'(b), 32'(eb));
    check({nm, " fault"}, 32'(fault), 32'(ef));
    check({nm, " fault_cnt"}, 32'(fault_cnt), 32'(ec));
    @(posedge clk); #1;
    inj = 3'b000;
    @(negedge clk);
    check({nm, " done width"}, 32'(done), 0);
    check({nm, " d hold"}, 32'(d), 32'(ed));
  endtask

  task automatic run32(input string nm, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [2:0] iv);
    logic [31:0] md, ed;
    logic        mb, eb;
    int          mc, jd;
    logic        got;
    model(32, xv, yv, iv, -2, md, mb, mc);
    ed = (iv == 3'b000) ? (xv - yv) : md;
    eb = (iv == 3'b000) ? (xv < yv) : mb;
    @(posedge clk); #1;
    x32 = xv; y32 = yv; start32 = 1'b1; inj32 = iv;
    @(posedge clk); #1;
    start32 = 1'b0;
    got = 1'b0;
    jd  = -1;
    for (int j = 0; j < 40 && !got; j++) begin
      @(negedge clk);
      if (done32) begin
        got = 1'b1;
        jd  = j;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({nm, " latency"}, 32'(jd), 32);
    check({nm, " d"}, d32, ed);
    check({nm, " b"}, 32'(b32), 32'(eb));
    check({nm, " fault"}, 32'(fault32), 32'(mc != 0));
    check({nm, " fault_cnt"}, 32'(cnt32), 32'(mc));
    inj32 = 3'b000;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] inj;
    int         ic;
    logic [7:0] ed;
    logic       eb;
    logic       ef;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] md;
    logic        mb;
    int          mc;
    logic [7:0]  xv, yv, ed;
    logic        eb;
    logic [2:0]  iv;
    int          ic;
    int          dn;
    int          dt[4];
    logic [7:0]  dd[4];
    logic        db[4];

    vecs[0] = '{8'h5A, 8'h3C, 3'b000, -1, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 3'b000, -1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 3'b010,  2, 8'h0F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h01, 3'b011,  2, 8'h17, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h03, 3'b001,  7, 8'h02, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 3'b000, -1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 3'b000, -1, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 8'h80, 3'b000, -1, 8'h81, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'hFF, 3'b100,  0, 8'h01, 1'b1, 1'b1};

    // Reset, with start held high to show rst wins.
    rst = 1'b1; start = 1'b1; x = 8'hAA; y = 8'h55; inj = 3'b111;
    start32 = 1'b1; x32 = 32'h1234; y32 = 32'h1; inj32 = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst d", 32'(d), 0);
    check("rst b", 32'(b), 0);
    check("rst fault", 32'(fault), 0);
    check("rst fault_cnt", 32'(fault_cnt), 0);
    check("rst busy32", 32'(busy32), 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; inj = 3'b000; start32 = 1'b0; inj32 = 3'b000;
    @(negedge clk);
    check("idle after rst busy", 32'(busy), 0);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      model(8, {24'b0, vecs[i].x}, {24'b0, vecs[i].y}, vecs[i].inj, vecs[i].ic, md, mb, mc);
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].inj, vecs[i].ic,
             vecs[i].ed, vecs[i].eb, vecs[i].ef, 4'(mc));
    end

    // Random operands, optionally with an injection on one bit cycle.
    for (int t = 0; t < 24; t++) begin
      xv = 8'($urandom);
      yv = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        iv = 3'($urandom_range(1, 7));
        ic = int'($urandom_range(0, 7));
      end else begin
        iv = 3'b000;
        ic = -1;
      end
      model(8, {24'b0, xv}, {24'b0, yv}, iv, ic, md, mb, mc);
      ed = (ic < 0) ? 8'(xv - yv) : md[7:0];
      eb = (ic < 0) ? (xv < yv) : mb;
      run_op($sformatf("rnd%0d", t), xv, yv, iv, ic, ed, eb, mc != 0, 4'(mc));
    end

    // Start re-pulsed mid-RUN and during DONE must be ignored.
    dn = 0;
    for (int k = 0; k < 4; k++) begin dt[k] = -1; dd[k] = '0; db[k] = 1'b0; end
    @(posedge clk); #1;
    x = 8'h33; y = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (j == 3) begin start = 1'b1; x = 8'hFF; y = 8'h00; end
      else if (j == 8) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      if (done && dn < 4) begin dt[dn] = j; dd[dn] = d; db[dn] = b; dn++; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    check("repulse done count", 32'(dn), 1);
    check("repulse done time", 32'(dt[0]), 8);
    check("repulse d", 32'(dd[0]), 32'h22);
    check("repulse busy after", 32'(busy), 0);
    check("repulse d hold", 32'(d), 32'h22);

    // Reset in the middle of RUN, after a fault has been flagged.
    @(posedge clk); #1;
    x = 8'hAB; y = 8'h12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      inj = (j == 1) ? 3'b001 : 3'b000;
      @(posedge clk); #1;
    end
    inj = 3'b000;
    @(negedge clk);
    check("pre-rst fault", 32'(fault), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(busy), 0);
    check("midrst done", 32'(done), 0);
    check("midrst d", 32'(d), 0);
    check("midrst b", 32'(b), 0);
    check("midrst fault", 32'(fault), 0);
    check("midrst fault_cnt", 32'(fault_cnt), 0);
    run_op("after rst", 8'hFF, 8'hFF, 3'b000, -1, 8'h00, 1'b0, 1'b0, 4'd0);

    // Back-to-back operations: second start in the IDLE cycle after DONE.
    dn = 0;
    for (int k = 0; k < 4; k++) begin dt[k] = -1; dd[k] = '0; db[k] = 1'b0; end
    @(posedge clk); #1;
    x = 8'h80; y = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 22; j++) begin
      if (j == 9) begin x = 8'h01; y = 8'h80; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (done && dn < 4) begin dt[dn] = j; dd[dn] = d; db[dn] = b; dn++; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b done count", 32'(dn), 2);
    check("b2b first time", 32'(dt[0]), 8);
    check("b2b spacing", 32'(dt[1] - dt[0]), 10);
    check("b2b first d", 32'(dd[0]), 32'h7F);
    check("b2b first b", 32'(db[0]), 0);
    check("b2b second d", 32'(dd[1]), 32'h81);
    check("b2b second b", 32'(db[1]), 1);

    // Wide instance: fault-free, masked single replica, and saturation.
    run32("w32 plain", $urandom, $urandom, 3'b000);
    run32("w32 masked", $urandom, $urandom, 3'b010);
    run32("w32 sat", 32'h0, 32'h0, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
